// File: rtl/bram_stream_reader.sv
// Burst reader for one block-RAM port: reads COUNT words from BASE_ADDR and streams them out
// with tlast, hiding RAM latency and absorbing backpressure in a small skid FIFO.
module bram_stream_reader #(
  parameter int DW      = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int FIFO_D  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic          bram_regce,
  input  logic [DW-1:0] bram_dout,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [1:0]    dbg_state
);

  // Stream handshake: a word transfers on a cycle where m_tvalid and m_tready are both high;
  // once m_tvalid rises, m_tvalid/m_tdata/m_tlast hold until that transfer happens.

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + LATENCY + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [AW:0]         cnt_r;
  logic [AW:0]         issued;
  logic [AW:0]         popped;
  logic [AW-1:0]       addr_r;
  logic [LATENCY-1:0]  vpipe;
  logic [DW-1:0]       fifo_mem [FIFO_D];
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic [PW:0]         level;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       occ;
  logic                push;
  logic                pop;
  logic                issue;
  logic                credit_ok;
  logic                drain_empty;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(vpipe[i]);
    end
  end

  assign level    = wr_ptr - rd_ptr;
  assign push     = vpipe[LATENCY-1];
  assign m_tvalid = (level != '0);
  assign pop      = m_tvalid && m_tready;

  // Occupancy after this cycle if no read were issued: pushes only move words from
  // in-flight into the FIFO, so the sum changes only by this cycle's pop.
  assign occ       = inflight + CW'(level) - CW'(pop);
  assign credit_ok = (occ < CW'(FIFO_D));

  // The first read goes out in the start cycle itself so the first word reaches
  // m_tvalid LATENCY+1 cycles after start.
  always_comb begin
    issue = 1'b0;
    if (!rst) begin
      if (state == S_IDLE) begin
        issue = start && (count != '0);
      end else if (state == S_RUN) begin
        issue = (issued < cnt_r) && credit_ok;
      end
    end
  end

  assign drain_empty = (inflight == '0) && (level == {{PW{1'b0}}, pop});

  assign bram_en    = issue;
  assign bram_we    = 1'b0;
  assign bram_regce = 1'b1;
  assign bram_addr  = (state == S_IDLE) ? base_addr : addr_r;

  assign m_tdata   = fifo_mem[rd_ptr[PW-1:0]];
  assign m_tlast   = m_tvalid && (popped == cnt_r - (AW+1)'(1));
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr[PW-1:0]] <= bram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt_r  <= '0;
      issued <= '0;
      popped <= '0;
      addr_r <= '0;
      vpipe  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      wr_ptr <= wr_ptr + (PW+1)'(push);
      rd_ptr <= rd_ptr + (PW+1)'(pop);
      if (pop) begin
        popped <= popped + (AW+1)'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_r  <= count;
            popped <= '0;
            issued <= {{AW{1'b0}}, issue};
            addr_r <= next_addr(base_addr);
            state  <= (count == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            issued <= issued + (AW+1)'(1);
            addr_r <= next_addr(addr_r);
          end
          if (issued == cnt_r) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_empty) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level == (PW+1)'(FIFO_D))));

endmodule
